// File: rtl/enc_pkg.sv
// Shared constants and FSM state type for the 16-to-4 sequential priority encoder.
package enc_pkg;
    localparam int ENC_N = 16;
    localparam int ENC_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } enc_state_t;
endpackage

// File: rtl/prio_enc_16x4.sv
// Combinational 16-to-4 priority encoder: index 15 wins; also returns the winner as one-hot.
module prio_enc_16x4
    import enc_pkg::*;
(
    input  logic [ENC_N-1:0] i_vec,
    output logic [ENC_W-1:0] o_idx,
    output logic [ENC_N-1:0] o_onehot,
    output logic             o_any
);
    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        o_idx    = '0;
        o_onehot = '0;
        for (int i = 0; i < ENC_N; i++) begin
            if (i_vec[i]) begin
                o_idx    = ENC_W'(i);
                o_onehot = ENC_N'(1) << i;
            end
        end
    end

    assign o_any = |i_vec;
endmodule

// File: rtl/encoder_16x4_seq.sv
// Latches request pulses into a pending vector and presents them one code at a time,
// highest index first, over a valid/ack handshake; all outputs are registered.
module encoder_16x4_seq
    import enc_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ack,
    output logic [N-1:0] pending,
    output logic         merged
);
    enc_state_t   r_state;
    enc_state_t   w_next;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_code;
    logic         r_merged;

    logic [W-1:0] w_idx;
    logic [N-1:0] w_onehot;
    logic         w_any;
    logic         w_load;
    logic [N-1:0] w_clr;

    prio_enc_16x4 u_prio (
        .i_vec    (r_pending),
        .o_idx    (w_idx),
        .o_onehot (w_onehot),
        .o_any    (w_any)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load = 1'b1;
                    w_next = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    if (w_any) w_load = 1'b1;
                    else       w_next = IDLE;
                end
            end
        endcase
    end

    assign w_clr = w_load ? w_onehot : '0;

    // New requests are OR-ed in after the clear, so a request on the bit being loaded survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_code    <= '0;
            r_merged  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pending <= (r_pending & ~w_clr) | (e ? req : '0);
            r_merged  <= e & (|(req & r_pending & ~w_clr));
            if (w_load) r_code <= w_idx;
        end
    end

    assign code    = r_code;
    assign valid   = (r_state == PRESENT);
    assign pending = r_pending;
    assign merged  = r_merged;
endmodule

// File: tb/tb_encoder_16x4_seq.sv
// Directed bench for encoder_16x4_seq: queue-level reference model compared every cycle plus literal checks.
module tb_encoder_16x4_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        e   = 1'b0;
    logic [15:0] req = '0;
    logic        ack = 1'b0;
    logic [3:0]  code;
    logic        valid;
    logic [15:0] pending;
    logic        merged;

    int n_cmp  = 0;
    int n_fail = 0;
    int n7     = 0;

    encoder_16x4_seq dut (
        .clk     (clk),
        .rst     (rst),
        .e       (e),
        .req     (req),
        .code    (code),
        .valid   (valid),
        .ack     (ack),
        .pending (pending),
        .merged  (merged)
    );

    always #5 clk = ~clk;

    // Reference model: set of waiting request indices plus the code currently on offer.
    bit [15:0] m_pending;
    bit        m_valid;
    int        m_code;
    bit        m_merged;
    bit [15:0] m_p, m_removed;
    int        m_sel;
    bit        m_take;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending = '0;
            m_valid   = 1'b0;
            m_code    = 0;
            m_merged  = 1'b0;
        end else begin
            m_p   = m_pending;
            m_sel = -1;
            for (int i = 15; i >= 0; i--)
                if (m_p[i] && m_sel < 0) m_sel = i;
            m_take    = (m_sel >= 0) && (!m_valid || ack);
            m_removed = m_take ? (16'd1 << m_sel) : 16'd0;
            m_merged  = e && ((req & m_p & ~m_removed) != 16'd0);
            m_pending = (m_p & ~m_removed) | (e ? req : 16'd0);
            if (m_take) begin
                m_code  = m_sel;
                m_valid = 1'b1;
            end else if (m_valid && ack) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_valid",   int'(valid),   int'(m_valid));
            chk("model_code",    int'(code),    m_code);
            chk("model_pending", int'(pending), int'(m_pending));
            chk("model_merged",  int'(merged),  int'(m_merged));
            if (valid && code == 4'd7) n7++;
        end
    end

    task automatic cyc(input logic [15:0] r, input logic en, input logic a);
        @(negedge clk);
        req = r;
        e   = en;
        ack = a;
    endtask

    initial begin
        #1;
        chk("rst_valid",   int'(valid),   0);
        chk("rst_code",    int'(code),    0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_merged",  int'(merged),  0);
        @(negedge clk);
        rst = 1'b0;
        e   = 1'b1;

        // Single request
        cyc(16'h0020, 1, 1);
        cyc(16'h0000, 1, 1); chk("single_pend", int'(pending), 16'h0020); chk("single_v0", int'(valid), 0);
        cyc(16'h0000, 1, 1); chk("single_v1", int'(valid), 1); chk("single_code", int'(code), 5);
        cyc(16'h0000, 1, 1); chk("single_v2", int'(valid), 0); chk("single_hold", int'(code), 5);

        // Priority and back-to-back
        cyc(16'h0208, 1, 1);
        cyc(16'h0000, 1, 1);
        cyc(16'h0000, 1, 1); chk("b2b_code9", int'(code), 9); chk("b2b_v9", int'(valid), 1);
        cyc(16'h0000, 1, 1); chk("b2b_code3", int'(code), 3); chk("b2b_v3", int'(valid), 1);
        cyc(16'h0000, 1, 1); chk("b2b_end", int'(valid), 0);

        // Backpressure
        cyc(16'h8001, 1, 0);
        cyc(16'h0000, 1, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(16'h0000, 1, 0);
            chk("bp_code", int'(code), 15); chk("bp_valid", int'(valid), 1);
            chk("bp_pend", int'(pending), 16'h0001);
        end
        cyc(16'h0000, 1, 1); chk("bp_still15", int'(code), 15);
        cyc(16'h0000, 1, 1); chk("bp_code0", int'(code), 0); chk("bp_v0", int'(valid), 1);
        cyc(16'h0000, 1, 1); chk("bp_end", int'(valid), 0);

        // Merge: bit 7 re-pulsed while pending
        cyc(16'h8080, 1, 0);
        cyc(16'h0000, 1, 0);
        cyc(16'h0000, 1, 0); chk("mg_pend", int'(pending), 16'h0080);
        n7 = 0;
        cyc(16'h0080, 1, 0);
        cyc(16'h0000, 1, 0); chk("mg_pulse", int'(merged), 1); chk("mg_pend2", int'(pending), 16'h0080);
        cyc(16'h0000, 1, 1); chk("mg_once", int'(merged), 0);
        cyc(16'h0000, 1, 1); chk("mg_code7", int'(code), 7);
        cyc(16'h0000, 1, 1); chk("mg_end", int'(valid), 0);
        cyc(16'h0000, 1, 1); chk("mg_n7", n7, 1);

        // Set wins over clear: bit 7 re-pulsed on the edge it is loaded
        n7 = 0;
        cyc(16'h0080, 1, 1);
        cyc(16'h0080, 1, 1);
        cyc(16'h0000, 1, 1); chk("sw_code", int'(code), 7); chk("sw_pend", int'(pending), 16'h0080);
        chk("sw_nomerge", int'(merged), 0);
        cyc(16'h0000, 1, 1); chk("sw_code2", int'(code), 7); chk("sw_pend0", int'(pending), 0);
        cyc(16'h0000, 1, 1); chk("sw_end", int'(valid), 0);
        cyc(16'h0000, 1, 1); chk("sw_n7", n7, 2);

        // Enable low: capture frozen, draining continues
        cyc(16'h0003, 1, 0);
        cyc(16'h0000, 1, 0);
        cyc(16'hFFFF, 0, 0); chk("en_code1", int'(code), 1); chk("en_pend", int'(pending), 16'h0001);
        cyc(16'hFFFF, 0, 0); chk("en_pend2", int'(pending), 16'h0001); chk("en_merge", int'(merged), 0);
        cyc(16'hFFFF, 0, 1); chk("en_pend3", int'(pending), 16'h0001);
        cyc(16'hFFFF, 0, 1); chk("en_code0", int'(code), 0); chk("en_pend4", int'(pending), 0);
        cyc(16'hFFFF, 0, 1); chk("en_end", int'(valid), 0); chk("en_pend5", int'(pending), 0);

        // Asynchronous reset mid-operation
        cyc(16'h8000, 1, 0);
        cyc(16'h0420, 1, 0);
        cyc(16'h0000, 1, 0); chk("ar_pre_v", int'(valid), 1); chk("ar_pre_p", int'(pending), 16'h0420);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", int'(valid), 0); chk("ar_code", int'(code), 0);
        chk("ar_pend", int'(pending), 0); chk("ar_merged", int'(merged), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(16'h0000, 1, 1);
            chk("ar_quiet", int'(valid), 0);
        end
        cyc(16'h0004, 1, 1);
        cyc(16'h0000, 1, 1);
        cyc(16'h0000, 1, 1); chk("ar_new", int'(code), 2); chk("ar_new_v", int'(valid), 1);
        cyc(16'h0000, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
